// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

  // One instruction queue entry: the instruction and the PC it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_sync_fifo.sv
// Single-clock FIFO with push/pop/flush and an occupancy count.
// Push while full is accepted only together with a pop; flush overrides both.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  // Pointer and occupancy bookkeeping; explicit wrap keeps non power-of-two depths correct.
  // NOTE: sequential state is always assigned with <= so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + AW'(1);
      if (do_pop)  rptr <= (rptr == AW'(DEPTH - 1)) ? '0 : rptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

  // Storage write port.
  // NOTE: the data array has no reset; count/pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, issues word requests under a credit rule,
// tags responses with their PC and queues them for decode. A taken branch
// redirects the PC, flushes queued state and discards in-flight responses.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          DEPTH     = 4,
  parameter int          MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  input  logic        jump,
  input  logic        jaccept,
  input  logic [31:0] jaddr,
  output logic        misalign
);

  localparam int QAW = $clog2(DEPTH);
  localparam int QCW = QAW + 1;
  localparam int TAW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int OW  = $clog2(MAX_OUTST + 1);

  logic         redirect;
  logic         req_fire;
  logic         resp_keep;
  logic         q_push;
  logic         q_pop;
  logic         q_full;
  logic         q_empty;
  logic         tag_full;
  logic         tag_empty;
  logic [QCW-1:0] q_count;
  logic [TAW:0]   tag_count;
  logic [QCW:0]   credits_used;
  logic [31:0]    pc;
  logic [31:0]    pc_next;
  logic [31:0]    resp_pc;
  logic [OW-1:0]  outst_cnt;
  logic [OW-1:0]  outst_next;
  logic [OW-1:0]  discard_cnt;
  logic [OW-1:0]  discard_next;
  fetch_entry_t   q_wdata;
  fetch_entry_t   q_rdata;

  assign redirect = jump & jaccept;

  // Queue slots already committed: entries held plus responses still to arrive.
  assign credits_used   = {1'b0, q_count} + (QCW+1)'(outst_cnt);
  assign imem_req_valid = rst_n & ~redirect
                        & (outst_cnt < OW'(MAX_OUTST))
                        & (credits_used < (QCW+1)'(DEPTH));
  assign imem_addr      = pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // A response is kept only when it belongs to the current path.
  assign resp_keep = imem_rvalid & (discard_cnt == '0) & ~redirect;
  assign q_push    = resp_keep;
  assign q_wdata   = '{pc: resp_pc, instr: imem_rdata};

  assign dec_valid = ~q_empty & ~redirect;
  assign q_pop     = dec_valid & dec_ready;
  assign dec_instr = q_rdata.instr;
  assign dec_pc    = q_rdata.pc;

  // Next PC, outstanding count and discard count; redirect overrides accept.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pc_next      = pc;
    outst_next   = outst_cnt + OW'(req_fire) - OW'(imem_rvalid);
    discard_next = discard_cnt;
    if (redirect) begin
      pc_next      = {jaddr[31:2], 2'b00};
      discard_next = outst_cnt - OW'(imem_rvalid);
    end else begin
      if (req_fire) pc_next = pc + 32'd4;
      if (imem_rvalid && (discard_cnt != '0)) discard_next = discard_cnt - OW'(1);
    end
  end

  // Architectural fetch state and the one-cycle misalign pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      outst_cnt   <= '0;
      discard_cnt <= '0;
      misalign    <= 1'b0;
    end else begin
      pc          <= pc_next;
      outst_cnt   <= outst_next;
      discard_cnt <= discard_next;
      misalign    <= redirect & (jaddr[1:0] != 2'b00);
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_instr_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (q_push),
    .pop   (q_pop),
    .flush (redirect),
    .wdata (q_wdata),
    .rdata (q_rdata),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  // PCs of accepted requests, consumed in order by kept responses.
  sync_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUTST)
  ) u_tag_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_fire),
    .pop   (resp_keep),
    .flush (redirect),
    .wdata (pc),
    .rdata (resp_pc),
    .count (tag_count),
    .full  (tag_full),
    .empty (tag_empty)
  );

  // A response with nothing outstanding is an environment error.
  a_rvalid_has_req: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> (outst_cnt != '0));

  // The credit rule must leave room for every kept response.
  a_queue_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (q_push && !q_pop) |-> !q_full);

  // Tags exist exactly for the in-flight responses that will be kept.
  a_tag_balance: assert property (@(posedge clk) disable iff (!rst_n)
    int'(tag_count) == int'(outst_cnt) - int'(discard_cnt));

  a_tag_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    req_fire |-> !tag_full);

  a_tag_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    resp_keep |-> !tag_empty);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table driven against an
// in-order memory model, plus a hand sequence for back-to-back redirects and PC wrap.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        jump;
  logic        jaccept;
  logic [31:0] jaddr;
  logic        misalign;

  int total = 0;
  int bad   = 0;

  logic [31:0] pend [$];

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          mem;
    bit          drdy;
    bit          jmp;
    bit          jacc;
    logic [31:0] jaddr;
    bit          e_rv;
    logic [31:0] e_addr;
    bit          e_dv;
    logic [31:0] e_dpc;
    bit          e_mis;
  } vec_t;

  vec_t tbl [$];

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .jump           (jump),
    .jaccept        (jaccept),
    .jaddr          (jaddr),
    .misalign       (misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A00_0013;
  endfunction

  function automatic vec_t v(input bit rst, input bit rdy, input bit mem, input bit drdy,
                             input bit jmp, input bit jacc, input logic [31:0] ja,
                             input bit erv, input logic [31:0] eaddr,
                             input bit edv, input logic [31:0] edpc, input bit emis);
    vec_t r;
    r.rst = rst; r.rdy = rdy; r.mem = mem; r.drdy = drdy; r.jmp = jmp; r.jacc = jacc;
    r.jaddr = ja; r.e_rv = erv; r.e_addr = eaddr; r.e_dv = edv; r.e_dpc = edpc; r.e_mis = emis;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Called just after a falling edge: drive this cycle's inputs, then let them settle.
  task automatic cycle_begin(input bit rst, input bit rdy, input bit mem, input bit drdy,
                             input bit jmp, input bit jacc, input logic [31:0] ja);
    rst_n          = ~rst;
    imem_req_ready = rdy;
    dec_ready      = drdy;
    jump           = jmp;
    jaccept        = jacc;
    jaddr          = ja;
    if (rst) pend.delete();
    if (!rst && mem && pend.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(pend.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = INSTR_NOP;
    end
    #1;
  endtask

  // Record any request accepted at the coming rising edge, then move to the next falling edge.
  task automatic cycle_end();
    if (rst_n && imem_req_valid && imem_req_ready) pend.push_back(imem_addr);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;

    // Scenario A: streaming from reset with a 1-cycle memory.
    tbl.push_back(v(0,1,1,1,0,0,0,           1,32'h000, 0,32'h000, 0));
    tbl.push_back(v(0,1,1,1,0,0,0,           1,32'h004, 0,32'h000, 0));
    tbl.push_back(v(0,1,1,1,0,0,0,           1,32'h008, 1,32'h000, 0));
    tbl.push_back(v(0,1,1,1,0,0,0,           1,32'h00C, 1,32'h004, 0));
    tbl.push_back(v(0,1,1,1,0,0,0,           1,32'h010, 1,32'h008, 0));
    tbl.push_back(v(1,1,1,1,0,0,0,           0,32'h000, 0,32'h000, 0));
    // Scenario B: decode stalled, credits stop fetching after DEPTH accepts.
    tbl.push_back(v(0,1,1,0,0,0,0,           1,32'h000, 0,32'h000, 0));
    tbl.push_back(v(0,1,1,0,0,0,0,           1,32'h004, 0,32'h000, 0));
    tbl.push_back(v(0,1,1,0,0,0,0,           1,32'h008, 1,32'h000, 0));
    tbl.push_back(v(0,1,1,0,0,0,0,           1,32'h00C, 1,32'h000, 0));
    tbl.push_back(v(0,1,1,0,0,0,0,           0,32'h000, 1,32'h000, 0));
    tbl.push_back(v(0,1,1,0,0,0,0,           0,32'h000, 1,32'h000, 0));
    tbl.push_back(v(0,1,1,1,0,0,0,           0,32'h000, 1,32'h000, 0));
    tbl.push_back(v(0,1,1,1,0,0,0,           1,32'h010, 1,32'h004, 0));
    tbl.push_back(v(0,1,1,1,0,0,0,           1,32'h014, 1,32'h008, 0));
    tbl.push_back(v(0,1,1,1,0,0,0,           1,32'h018, 1,32'h00C, 0));
    tbl.push_back(v(1,1,1,1,0,0,0,           0,32'h000, 0,32'h000, 0));
    // Scenario C: redirect with two in flight, not-taken branch, redirect on a response, reset.
    tbl.push_back(v(0,1,0,1,0,0,0,           1,32'h000, 0,32'h000, 0));
    tbl.push_back(v(0,1,0,1,0,0,0,           1,32'h004, 0,32'h000, 0));
    tbl.push_back(v(0,1,0,1,1,1,32'h100,     0,32'h000, 0,32'h000, 0));
    tbl.push_back(v(0,1,1,1,0,0,0,           0,32'h000, 0,32'h000, 0));
    tbl.push_back(v(0,1,1,1,0,0,0,           1,32'h100, 0,32'h000, 0));
    tbl.push_back(v(0,1,1,1,0,0,0,           1,32'h104, 0,32'h000, 0));
    tbl.push_back(v(0,1,1,1,0,0,0,           1,32'h108, 1,32'h100, 0));
    tbl.push_back(v(0,1,1,1,1,0,32'h300,     1,32'h10C, 1,32'h104, 0));
    tbl.push_back(v(0,1,1,1,0,0,0,           1,32'h110, 1,32'h108, 0));
    tbl.push_back(v(0,1,1,1,1,1,32'h203,     0,32'h000, 0,32'h000, 0));
    tbl.push_back(v(0,1,1,1,0,0,0,           1,32'h200, 0,32'h000, 1));
    tbl.push_back(v(0,1,1,1,0,0,0,           1,32'h204, 0,32'h000, 0));
    tbl.push_back(v(0,1,1,1,0,0,0,           1,32'h208, 1,32'h200, 0));
    tbl.push_back(v(1,1,1,1,0,0,0,           0,32'h000, 0,32'h000, 0));
    tbl.push_back(v(0,1,1,1,0,0,0,           1,32'h000, 0,32'h000, 0));

    rst_n = 1'b0; imem_req_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = INSTR_NOP;
    dec_ready = 1'b0; jump = 1'b0; jaccept = 1'b0; jaddr = '0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      cycle_begin(tbl[i].rst, tbl[i].rdy, tbl[i].mem, tbl[i].drdy,
                  tbl[i].jmp, tbl[i].jacc, tbl[i].jaddr);
      check($sformatf("row%0d req_valid", i), 32'(imem_req_valid), 32'(tbl[i].e_rv));
      check($sformatf("row%0d dec_valid", i), 32'(dec_valid), 32'(tbl[i].e_dv));
      check($sformatf("row%0d misalign", i), 32'(misalign), 32'(tbl[i].e_mis));
      if (tbl[i].e_rv) check($sformatf("row%0d imem_addr", i), imem_addr, tbl[i].e_addr);
      if (tbl[i].e_dv) begin
        check($sformatf("row%0d dec_pc", i), dec_pc, tbl[i].e_dpc);
        check($sformatf("row%0d dec_instr", i), dec_instr, instr_of(tbl[i].e_dpc));
      end
      cycle_end();
    end

    // Hand sequence: two requests in flight, back-to-back redirects, second lands at the top PC.
    cycle_begin(1,1,0,1,0,0,0);
    cycle_end();
    cycle_begin(0,1,0,1,0,0,0);
    check("h fire0 addr", imem_addr, 32'h0);
    cycle_end();
    cycle_begin(0,1,0,1,0,0,0);
    check("h fire1 addr", imem_addr, 32'h4);
    cycle_end();
    cycle_begin(0,1,0,1,1,1,32'h400);
    check("h redir1 req_valid", 32'(imem_req_valid), 32'd0);
    cycle_end();
    cycle_begin(0,1,1,1,1,1,32'hFFFF_FFFC);
    check("h redir2 req_valid", 32'(imem_req_valid), 32'd0);
    check("h redir2 dec_valid", 32'(dec_valid), 32'd0);
    cycle_end();
    cycle_begin(0,1,1,1,0,0,0);
    check("h top req_valid", 32'(imem_req_valid), 32'd1);
    check("h top addr", imem_addr, 32'hFFFF_FFFC);
    check("h top misalign", 32'(misalign), 32'd0);
    cycle_end();
    cycle_begin(0,1,1,1,0,0,0);
    check("h wrap addr", imem_addr, 32'h0);
    cycle_end();

    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle_begin(0,1,1,1,0,0,0);
      found = dec_valid;
      if (found) begin
        check("h first dec_pc", dec_pc, 32'hFFFF_FFFC);
        check("h first dec_instr", dec_instr, instr_of(32'hFFFF_FFFC));
      end
      cycle_end();
      if (found) break;
    end
    check("h dec_valid seen", 32'(found), 32'd1);

    cycle_begin(0,1,1,1,0,0,0);
    check("h wrap dec_valid", 32'(dec_valid), 32'd1);
    check("h wrap dec_pc", dec_pc, 32'h0);
    cycle_end();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Front-end fetch stage that feeds decode and, through decode, the branch-detect stage.
- Owns the architectural fetch PC and issues word requests to instruction memory.
- Buffers returned instructions with their PCs in a small FIFO.
- On a taken branch or jalr (jump & jaccept), redirects to jaddr, flushes wrong-path state and discards in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- DEPTH, 4, instruction queue entries (power of two, ≥2).
- MAX_OUTST, 2, max outstanding imem requests (≤ DEPTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, active-low, asynchronous assert, synchronous deassert outside block.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  32  word-aligned request address (current PC).
- imem_rvalid  in  1  response valid (in request order; always accepted).
- imem_rdata  in  32  returned instruction.
- dec_valid  out  1  queue head valid toward decode.
- dec_ready  in  1  decode consumes head.
- dec_instr  out  32  head instruction.
- dec_pc  out  32  head PC (fetch_pc for branch-detect).
- jump  in  1  branch/jalr detected.
- jaccept  in  1  branch taken.
- jaddr  in  32  redirect target.
- misalign  out  1  one-cycle pulse: redirect target had jaddr[1:0] != 0.

Behaviour:
- Clock/reset are fixed: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - pc = RESET_PC; queue empty; outst_cnt = 0; discard_cnt = 0; misalign = 0.
  - Hence imem_req_valid = 0 and dec_valid = 0 while rst_n low.
- redirect = jump & jaccept (combinational). jump & ~jaccept is a not-taken branch: no effect.
- Request issue:
  - imem_req_valid = ~redirect & (outst_cnt < MAX_OUTST) & (count + outst_cnt < DEPTH).
  - The credit rule guarantees a response always has a free queue slot.
  - Request accepted = valid & ready. On accept, pc += 4 and outst_cnt increments.
  - imem_addr is valid only while imem_req_valid is high.
- Response:
  - Each imem_rvalid decrements outst_cnt.
  - If discard_cnt > 0: response dropped, discard_cnt decrements.
  - Otherwise push {resp_pc, imem_rdata}. resp_pc comes from a PC tag FIFO of depth MAX_OUTST, written at request accept.
- Decode handshake:
  - dec_valid = (count != 0) & ~redirect.
  - Pop on dec_valid & dec_ready.
  - Push and pop in the same cycle keep count unchanged, including when full.
- Redirect (edge at end of cycle where redirect = 1):
  - Queue cleared; tag FIFO cleared.
  - pc = {jaddr[31:2], 2'b00}.
  - discard_cnt = outst_cnt − (imem_rvalid this cycle ? 1 : 0). The same-cycle response is dropped, never pushed.
  - outst_cnt updated normally for that cycle's response. No request is issued in the redirect cycle.
  - misalign = (jaddr[1:0] != 0) for exactly the next cycle.
- Redirect precedence: redirect overrides push, pop and request accept in the same cycle.
- First target request is issued the cycle after redirect, provided credits allow. Redirect-to-first-request latency is 1 cycle.
- Back-to-back redirects: the later one wins. discard_cnt is recomputed from current outst_cnt and pending discards, i.e. all in-flight responses.
- PC wrap: 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- Min latency from request accept to dec_valid: 1 cycle after imem_rvalid (registered queue).
- rst_n asserted mid-operation: all state returns to reset values immediately. Responses arriving after release with no matching request are an environment error; an SVA assertion checks outst_cnt != 0 on every imem_rvalid.

Decomposition:
- Shared package fetch_pkg: RESET_PC default, typedef fetch_entry_t {pc[31:0], instr[31:0]}, INSTR_NOP = 32'h0000_0013.
- One natural sub-module: sync_fifo (parameterised width/depth, push/pop/flush, count, full/empty).
  - Instantiated twice: instruction queue (64-bit entries) and PC tag FIFO.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle memory → imem_addr 0x0, 0x4, 0x8, 0xC; dec_pc/dec_instr appear in order; dec_valid first high 2 cycles after first accept.
- dec_ready=0, memory always ready → exactly DEPTH=4 requests accepted, then imem_req_valid stays 0; raising dec_ready resumes fetching at 0x10.
- Two requests outstanding, then jump=1 jaccept=1 jaddr=0x100 → queue empty, next imem_addr=0x100, two stale responses dropped, first dec_pc=0x100.
- jump=1, jaccept=0 with queue non-empty → no flush; fetch sequence continues at pc+4.
- Redirect in the same cycle as imem_rvalid and dec_ready → neither pushed nor popped; discard_cnt = outst_cnt − 1; dec_valid low that cycle.
- jaddr=0x203 taken → imem_addr=0x200, misalign pulses for one cycle; rst_n dropped mid-stream → imem_addr returns to RESET_PC after release, dec_valid=0.
